// File: rtl/fwd_scoreboard.sv
// Forwarding / hazard scoreboard for the deep pipeline.
// Tracks in-flight register writes in a DEPTH-stage shift register. Each entry
// carries a countdown until its result can be bypassed. For every operand read
// port the youngest matching producer is selected as the bypass source, or a
// hazard is raised when that producer's result is not ready yet.
// Optional feature macro: FWDSB_STATS_EN (stall / forward statistics counters).
module fwd_scoreboard #(
   parameter int DEPTH = 3,
   parameter int NRD   = 2,
   parameter int AW    = 5,
   parameter int LW    = 2,
   parameter int FW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   input  logic              iss_wen,
   input  logic [AW-1:0]     iss_waddr,
   input  logic [LW-1:0]     iss_lat,
   output logic              iss_ready,
   input  logic [NRD-1:0]    rd_en,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*FW-1:0] rd_fwd,
   output logic [NRD-1:0]    rd_hzd,
   input  logic [DEPTH-1:0]  kill
`ifdef FWDSB_STATS_EN
   ,
   output logic [31:0]       stat_stall,
   output logic [31:0]       stat_fwd
`endif
);

   // Latency is capped so every producer is forwardable before it retires.
   localparam logic [LW-1:0] MAX_REM = LW'(DEPTH - 1);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [AW-1:0]    waddr_q [DEPTH];
   logic [AW-1:0]    waddr_d [DEPTH];
   logic [LW-1:0]    rem_q   [DEPTH];
   logic [LW-1:0]    rem_d   [DEPTH];
   logic             iss_acc;

   // Operand lookup: scan oldest to youngest so the youngest match wins.
   // Deliberately independent of iss_* to avoid a loop through iss_ready.
   always_comb begin
      rd_fwd = '0;
      rd_hzd = '0;
      for (int i = 0; i < NRD; i++) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rd_en[i] && (rd_addr[i*AW +: AW] != '0) && vld_q[k] && !kill[k] &&
                (waddr_q[k] == rd_addr[i*AW +: AW])) begin
               if (rem_q[k] == '0) begin
                  rd_fwd[i*FW +: FW] = FW'(k + 1);
                  rd_hzd[i]          = 1'b0;
               end else begin
                  rd_fwd[i*FW +: FW] = '0;
                  rd_hzd[i]          = 1'b1;
               end
            end
         end
      end
   end

   assign iss_ready = ~|rd_hzd;
   assign iss_acc   = iss_valid & iss_ready;

   // Next-state: kill first, then shift; stage 0 takes the accepted write or a bubble.
   always_comb begin
      vld_d[0]   = iss_acc & iss_wen & (iss_waddr != '0);
      waddr_d[0] = iss_waddr;
      rem_d[0]   = (iss_lat > MAX_REM) ? MAX_REM : iss_lat;
      for (int k = 0; k < DEPTH - 1; k++) begin
         vld_d[k+1]   = vld_q[k] & ~kill[k];
         waddr_d[k+1] = waddr_q[k];
         rem_d[k+1]   = (rem_q[k] == '0) ? '0 : rem_q[k] - 1'b1;
      end
   end

   // Control state (valid flags, countdowns) with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k < DEPTH; k++) rem_q[k] <= '0;
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < DEPTH; k++) rem_q[k] <= rem_d[k];
      end
   end

   // Destination addresses are qualified by vld, so they need no reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) waddr_q[k] <= waddr_d[k];
   end

`ifdef FWDSB_STATS_EN
   logic [31:0] stat_stall_q, stat_stall_d;
   logic [31:0] stat_fwd_q,   stat_fwd_d;
   logic [31:0] fwd_cnt;

   // Statistics: stall cycles and operands bypassed on accepted issues.
   always_comb begin
      fwd_cnt = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rd_fwd[i*FW +: FW] != '0) fwd_cnt = fwd_cnt + 32'd1;
      end
      stat_stall_d = stat_stall_q + {31'd0, iss_valid & ~iss_ready};
      stat_fwd_d   = iss_acc ? stat_fwd_q + fwd_cnt : stat_fwd_q;
   end

   // Counter registers, wrapping naturally at 2**32.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_q <= '0;
         stat_fwd_q   <= '0;
      end else begin
         stat_stall_q <= stat_stall_d;
         stat_fwd_q   <= stat_fwd_d;
      end
   end

   assign stat_stall = stat_stall_q;
   assign stat_fwd   = stat_fwd_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard (DEPTH=3, NRD=2, AW=5, LW=2).
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns later.
module tb_fwd_scoreboard;
   localparam int DEPTH = 3;
   localparam int NRD   = 2;
   localparam int AW    = 5;
   localparam int LW    = 2;
   localparam int FW    = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              iss_valid;
   logic              iss_wen;
   logic [AW-1:0]     iss_waddr;
   logic [LW-1:0]     iss_lat;
   logic              iss_ready;
   logic [NRD-1:0]    rd_en;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*FW-1:0] rd_fwd;
   logic [NRD-1:0]    rd_hzd;
   logic [DEPTH-1:0]  kill;
`ifdef FWDSB_STATS_EN
   logic [31:0]       stat_stall;
   logic [31:0]       stat_fwd;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   fwd_scoreboard #(.DEPTH(DEPTH), .NRD(NRD), .AW(AW), .LW(LW), .FW(FW)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_waddr(iss_waddr), .iss_lat(iss_lat),
      .iss_ready(iss_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_fwd(rd_fwd), .rd_hzd(rd_hzd),
      .kill(kill)
`ifdef FWDSB_STATS_EN
      , .stat_stall(stat_stall), .stat_fwd(stat_fwd)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_valid = 1'b0; iss_wen = 1'b0; iss_waddr = '0; iss_lat = '0;
      rd_en = '0; rd_addr = '0; kill = '0;
   endtask

   task automatic issue(input logic [AW-1:0] a, input logic [LW-1:0] lat);
      iss_valid = 1'b1; iss_wen = 1'b1; iss_waddr = a; iss_lat = lat;
   endtask

   task automatic rd(input logic [1:0] en, input logic [AW-1:0] a1, input logic [AW-1:0] a0);
      rd_en = en; rd_addr = {a1, a0};
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;

      // Reset state
      rd(2'b11, 5'd5, 5'd7); #2;
      check("rst_fwd", 32'(rd_fwd), 0);
      check("rst_hzd", 32'(rd_hzd), 0);
      check("rst_ready", 32'(iss_ready), 1);

      // T2 load-use with issue held during the stall
      idle(); issue(5'd7, 2'd1); #2;
      check("t2_ready0", 32'(iss_ready), 1);
      step();
      idle(); iss_valid = 1'b1; rd(2'b10, 5'd7, 5'd0); #2;
      check("t2_hzd", 32'(rd_hzd), 32'b10);
      check("t2_fwd_stall", 32'(rd_fwd), 0);
      check("t2_ready_stall", 32'(iss_ready), 0);
      step(); #2;
      check("t2_fwd", 32'(rd_fwd), 32'(2 << FW));
      check("t2_hzd_clr", 32'(rd_hzd), 0);
      check("t2_ready", 32'(iss_ready), 1);
      step(); idle(); #2;
`ifdef FWDSB_STATS_EN
      check("t6_stall", stat_stall, 1);
      check("t6_fwd", stat_fwd, 1);
`endif

      // T1 ALU chain through all stages and retirement
      issue(5'd5, 2'd0); #2;
      check("t1_ready0", 32'(iss_ready), 1);
      step(); idle(); rd(2'b01, 5'd0, 5'd5); #2;
      check("t1_fwd_s0", 32'(rd_fwd), 1);
      check("t1_ready1", 32'(iss_ready), 1);
      step(); #2;
      check("t1_fwd_s1", 32'(rd_fwd), 2);
      step(); #2;
      check("t1_fwd_s2", 32'(rd_fwd), 3);
      step(); #2;
      check("t1_retired", 32'(rd_fwd), 0);

      // Latency cap: lat 3 becomes 2, forwardable only from stage 2
      idle(); issue(5'd4, 2'd3); step();
      idle(); rd(2'b01, 5'd0, 5'd4); #2;
      check("cap_hzd_s0", 32'(rd_hzd), 1);
      step(); #2;
      check("cap_hzd_s1", 32'(rd_hzd), 1);
      step(); #2;
      check("cap_fwd_s2", 32'(rd_fwd), 3);
      check("cap_hzd_s2", 32'(rd_hzd), 0);
      step(); idle();

      // T3 youngest producer wins, both ports at once
      issue(5'd3, 2'd0); step();
      issue(5'd3, 2'd0); step();
      idle(); rd(2'b11, 5'd3, 5'd3); #2;
      check("t3_young", 32'(rd_fwd), 32'((1 << FW) | 1));
      step(); #2;
      check("t3_s1", 32'(rd_fwd), 32'((2 << FW) | 2));
      step(); #2;
      check("t3_s2_only", 32'(rd_fwd), 32'((3 << FW) | 3));
      step(); #2;
      check("t3_retired", 32'(rd_fwd), 0);
      step(); idle();

      // T4 r0 writes and disabled ports
      issue(5'd0, 2'd0); step();
      idle(); rd(2'b01, 5'd0, 5'd0); #2;
      check("t4_r0_fwd", 32'(rd_fwd), 0);
      check("t4_r0_hzd", 32'(rd_hzd), 0);
      step(); idle(); issue(5'd5, 2'd1); step();
      idle(); rd(2'b00, 5'd5, 5'd5); #2;
      check("t4_rden_fwd", 32'(rd_fwd), 0);
      check("t4_rden_hzd", 32'(rd_hzd), 0);
      step(); idle(); issue(5'd6, 2'd0); iss_wen = 1'b0; step();
      idle(); rd(2'b01, 5'd0, 5'd6); #2;
      check("t4_nowen", 32'(rd_fwd), 0);
      step(); idle(); step(); step(); step();

      // T5 kill: masks lookup, removes the entry, spares concurrent issue
      issue(5'd9, 2'd2); step();
      idle(); kill = 3'b001; rd(2'b01, 5'd0, 5'd9); #2;
      check("t5_kill_hzd", 32'(rd_hzd), 0);
      check("t5_kill_fwd", 32'(rd_fwd), 0);
      step(); kill = '0; #2;
      check("t5_killed_gone", 32'(rd_hzd), 0);
      step(); idle();
      issue(5'd10, 2'd1); step();
      issue(5'd10, 2'd0); kill = 3'b001; rd(2'b01, 5'd0, 5'd10); #2;
      check("t5_k0_ready", 32'(iss_ready), 1);
      check("t5_k0_hzd", 32'(rd_hzd), 0);
      step(); idle(); rd(2'b01, 5'd0, 5'd10); #2;
      check("t5_issue_kept", 32'(rd_fwd), 1);
      step(); idle(); step(); step();
      issue(5'd11, 2'd0); step(); idle(); step();
      kill = 3'b010; rd(2'b01, 5'd0, 5'd11); #2;
      check("t5_kill1", 32'(rd_fwd), 0);
      step(); idle(); step(); step();

      // T5 reset with three valid entries and a concurrent issue
      issue(5'd1, 2'd1); step();
      issue(5'd2, 2'd1); step();
      issue(5'd12, 2'd1); step();
      issue(5'd13, 2'd0); rst = 1'b1; step();
      rst = 1'b0; idle(); rd(2'b11, 5'd12, 5'd13); #2;
      check("t5_rst_fwd", 32'(rd_fwd), 0);
      check("t5_rst_hzd", 32'(rd_hzd), 0);
      check("t5_rst_ready", 32'(iss_ready), 1);
`ifdef FWDSB_STATS_EN
      check("t5_rst_stall", stat_stall, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
